pwm_multi_ch: RTL and testbench

//  Parametrised N-channel PWM peripheral on a RIB slave port; successor to the fixed write-only PWM.

---
 rtl/pwm_multi_ch_if.sv | 16 +
 rtl/pwm_multi_ch.sv | 174 +++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_ch_if.sv
// RIB register bus carrying one write strobe, an address, write data and read data.
// Latency: writes land on the clk edge with we_i high; read data is combinational from addr_i.
// Backpressure: none, every access completes in the cycle it is presented.
//   we_i    master -> slave  write strobe
//   addr_i  master -> slave  byte address; the slave decodes addr_i[7:0]
//   data_i  master -> slave  write data
//   data_o  slave -> master  read data
interface pwm_multi_ch_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, addr_i, data_i, input data_o);
  modport slave  (input we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/pwm_multi_ch.sv
// N-channel PWM with prescaler, edge/centre counting, shadowed PERIOD/DUTY and a period interrupt.
// Latency: pwm_o is registered one cycle behind the counter; register reads are zero latency.
// Backpressure: none, the RIB slave accepts every access.
//   clk, rst  system clock and synchronous active-high reset
//   bus       RIB slave port (we_i, addr_i, data_i, data_o)
//   pwm_o     per-channel PWM outputs, registered
//   irq_o     period interrupt level (EVT & IRQ_EN)
module pwm_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PSC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  pwm_multi_ch_if.slave     bus,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq_o
);

  // Control and shadow registers
  logic              en, mode, irq_en;
  logic [NUM_CH-1:0] ch_en, pol;
  logic [CNT_W-1:0]  period_sh;
  logic [PSC_W-1:0]  psc;
  logic [CNT_W-1:0]  duty_sh [NUM_CH];

  // Active set and run state
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  duty_act [NUM_CH];
  logic [CNT_W-1:0]  cnt;
  logic [PSC_W-1:0]  psc_cnt;
  logic              dir, evt, upd_pend;

  // Address decode
  logic [7:0]  offset;
  logic [2:0]  duty_idx;
  logic        duty_hit;
  logic        wr_ctrl, wr_period, wr_psc, wr_status, wr_duty;
  logic [31:0] rdata;
  logic        unused_bus;

  assign offset    = bus.addr_i[7:0];
  assign duty_idx  = offset[4:2];
  assign duty_hit  = (offset[7:5] == 3'b001) && (offset[1:0] == 2'b00) && (int'(duty_idx) < NUM_CH);
  assign wr_ctrl   = bus.we_i && (offset == 8'h00);
  assign wr_period = bus.we_i && (offset == 8'h04);
  assign wr_psc    = bus.we_i && (offset == 8'h08);
  assign wr_status = bus.we_i && (offset == 8'h0C);
  assign wr_duty   = bus.we_i && duty_hit;
  assign unused_bus = ^{bus.addr_i[31:8], bus.data_i};

  // Timebase: one tick per PSC+1 cycles, only while enabled
  logic tick, boundary, load;
  assign tick = en && (psc_cnt == psc);
  // Edge mode ends a period at the top; centre mode ends it on the down-count reaching 0.
  // A zero period makes every tick a boundary.
  assign boundary = tick && ((period_act == '0) ||
                             (mode ? (dir && (cnt == '0)) : (cnt >= period_act)));
  assign load = boundary && upd_pend;

  assign irq_o = evt && irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      en         <= 1'b0;
      mode       <= 1'b0;
      irq_en     <= 1'b0;
      ch_en      <= '0;
      pol        <= '0;
      period_sh  <= '0;
      psc        <= '0;
      period_act <= '0;
      cnt        <= '0;
      psc_cnt    <= '0;
      dir        <= 1'b0;
      evt        <= 1'b0;
      upd_pend   <= 1'b0;
      pwm_o      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (wr_ctrl) begin
        en     <= bus.data_i[0];
        mode   <= bus.data_i[1];
        irq_en <= bus.data_i[3];
        ch_en  <= bus.data_i[8 +: NUM_CH];
        pol    <= bus.data_i[16 +: NUM_CH];
      end
      if (wr_period) period_sh <= bus.data_i[CNT_W-1:0];
      if (wr_psc)    psc       <= bus.data_i[PSC_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty && (duty_idx == i[2:0])) duty_sh[i] <= bus.data_i[CNT_W-1:0];
      end

      // A boundary in the same cycle as the W1C keeps the event visible
      if (boundary)                         evt <= 1'b1;
      else if (wr_status && bus.data_i[0])  evt <= 1'b0;

      // A fresh UPD request beats the clear from a coincident boundary
      if (!en)                              upd_pend <= 1'b0;
      else if (wr_ctrl && bus.data_i[2])    upd_pend <= 1'b1;
      else if (load)                        upd_pend <= 1'b0;

      // Disabled: active set tracks the shadows so the first period after enable is clean
      if (!en || load) begin
        period_act <= period_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      end

      if (!en) begin
        psc_cnt <= '0;
        cnt     <= '0;
        dir     <= 1'b0;
      end else begin
        psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
        if (tick) begin
          if (period_act == '0) begin
            cnt <= '0;
            dir <= 1'b0;
          end else if (!mode) begin
            cnt <= (cnt >= period_act) ? '0 : cnt + CNT_W'(1);
            dir <= 1'b0;
          end else if (!dir) begin
            // Turn around at the top; the top value is held for exactly one tick
            if (cnt >= period_act) begin
              dir <= 1'b1;
              cnt <= cnt - CNT_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            if (cnt == '0) begin
              dir <= 1'b0;
              cnt <= cnt + CNT_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        pwm_o[i] <= (en && ch_en[i]) ? ((cnt < duty_act[i]) ^ pol[i]) : pol[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      8'h00: begin
        rdata[0]             = en;
        rdata[1]             = mode;
        rdata[3]             = irq_en;
        rdata[8 +: NUM_CH]   = ch_en;
        rdata[16 +: NUM_CH]  = pol;
      end
      8'h04:   rdata[CNT_W-1:0] = period_sh;
      8'h08:   rdata[PSC_W-1:0] = psc;
      8'h0C:   rdata[2:0]       = {dir, upd_pend, evt};
      8'h10:   rdata[CNT_W-1:0] = cnt;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (duty_hit && (duty_idx == i[2:0])) rdata[CNT_W-1:0] = duty_sh[i];
        end
      end
    endcase
  end

  assign bus.data_o = rdata;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed testbench for pwm_multi_ch: reset, edge and centre counting, shadow update,
// duty/polarity limits, zero period with prescaler, interrupt W1C and reset mid-run.
module tb_pwm_multi_ch;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] pwm_o;
  logic              irq_o;
  int                checks = 0;
  int                errors = 0;

  pwm_multi_ch_if bus ();

  pwm_multi_ch #(.NUM_CH(NUM_CH), .CNT_W(16), .PSC_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .pwm_o (pwm_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  logic [31:0] reg_addrs [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h24, 32'h28, 32'h2C};
  logic [31:0] lim_duty  [6] = '{32'd0, 32'd10, 32'd0, 32'd10, 32'd3, 32'd3};
  logic [31:0] lim_ctrl  [6] = '{32'h101, 32'h101, 32'h10101, 32'h10101, 32'h10001, 32'h00001};
  logic        lim_exp   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a;
    bus.data_i = d;
    bus.we_i   = 1'b1;
    @(negedge clk);
    bus.we_i   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr_i = a;
    #1;
    d = bus.data_o;
  endtask

  // Drive a write that lands on the coming rising edge; the next negedge drops we_i.
  task automatic sched_wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i = a;
    bus.data_i = d;
    bus.we_i   = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    bus.we_i = 1'b0;
    bus.addr_i = '0;
    bus.data_i = '0;
    repeat (2) @(negedge clk);
    checks++; if (pwm_o !== 4'b0000) begin errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    for (int r = 0; r < 9; r++) begin
      rd(reg_addrs[r], d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg %h: got %h expected 0", reg_addrs[r], d); end
    end
    rst = 1'b0;
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h30, 32'hFFFF_FFFF);
    wr(32'h04, 32'hFFFF_FFFF);
    rd(32'h14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_14: got %h expected 0", d); end
    rd(32'h30, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_30: got %h expected 0", d); end
    rd(32'h2C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL duty3_untouched: got %h expected 0", d); end
    rd(32'h04, d);
    checks++; if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL period_width: got %h expected 0000ffff", d); end
    wr(32'h04, 32'h0);
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic        ep, ee;
    wr(32'h04, 32'd9);
    wr(32'h08, 32'd0);
    wr(32'h20, 32'd3);
    wr(32'h00, 32'h101);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      bus.we_i = 1'b0;
      ep = ((k - 1) % 10) < 3;
      checks++; if (pwm_o !== {3'b000, ep}) begin errors++; $display("FAIL edge_pwm k=%0d: got %b expected %b", k, pwm_o, {3'b000, ep}); end
      rd(32'h0C, d);
      ee = (k >= 10 && k < 13) || (k >= 20);
      checks++; if (d !== {31'd0, ee}) begin errors++; $display("FAIL edge_status k=%0d: got %h expected %h", k, d, {31'd0, ee}); end
      if (k == 12) sched_wr(32'h0C, 32'h1);
    end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_centre();
    logic [31:0] d;
    logic        ep, ee;
    int          cnt_tab [18] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    logic        dir_tab [18] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    wr(32'h0C, 32'h1);
    wr(32'h04, 32'd4);
    wr(32'h20, 32'd2);
    wr(32'h00, 32'h103);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      bus.we_i = 1'b0;
      ep = cnt_tab[k-1] < 2;
      checks++; if (pwm_o !== {3'b000, ep}) begin errors++; $display("FAIL centre_pwm k=%0d: got %b expected %b", k, pwm_o, {3'b000, ep}); end
      rd(32'h10, d);
      checks++; if (d !== 32'(cnt_tab[k])) begin errors++; $display("FAIL centre_count k=%0d: got %0d expected %0d", k, d, cnt_tab[k]); end
      rd(32'h0C, d);
      ee = (k == 9) || (k == 10) || (k >= 17);
      checks++; if (d !== {29'd0, dir_tab[k], 1'b0, ee}) begin errors++; $display("FAIL centre_status k=%0d: got %h expected %h", k, d, {29'd0, dir_tab[k], 1'b0, ee}); end
      if (k == 10) sched_wr(32'h0C, 32'h1);
    end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_shadow();
    logic [31:0] d;
    logic        ep, eu, ee;
    int          m;
    wr(32'h0C, 32'h1);
    wr(32'h04, 32'd9);
    wr(32'h20, 32'd3);
    wr(32'h00, 32'h101);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bus.we_i = 1'b0;
      m = k - 1;
      ep = (m % 10) < ((m >= 20) ? 7 : 3);
      checks++; if (pwm_o !== {3'b000, ep}) begin errors++; $display("FAIL shadow_pwm k=%0d: got %b expected %b", k, pwm_o, {3'b000, ep}); end
      rd(32'h0C, d);
      eu = (k >= 15) && (k < 20);
      ee = (k >= 10);
      checks++; if (d !== {30'd0, eu, ee}) begin errors++; $display("FAIL shadow_status k=%0d: got %h expected %h", k, d, {30'd0, eu, ee}); end
      if (k == 5) begin
        rd(32'h20, d);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL shadow_duty_read: got %h expected 7", d); end
      end
      if (k == 16) begin
        rd(32'h00, d);
        checks++; if (d !== 32'h101) begin errors++; $display("FAIL ctrl_upd_reads0: got %h expected 101", d); end
      end
      if (k == 2)  sched_wr(32'h20, 32'd7);
      if (k == 14) sched_wr(32'h00, 32'h105);
    end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_limits();
    logic [31:0] d;
    wr(32'h04, 32'd9);
    wr(32'h08, 32'd0);
    for (int c = 0; c < 6; c++) begin
      wr(32'h20, lim_duty[c]);
      wr(32'h00, lim_ctrl[c]);
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        checks++; if (pwm_o !== {3'b000, lim_exp[c]}) begin errors++; $display("FAIL limit_pwm case=%0d k=%0d: got %b expected %b", c, k, pwm_o, {3'b000, lim_exp[c]}); end
      end
      wr(32'h00, 32'h0);
      checks++; if (pwm_o !== {3'b000, lim_exp[c]}) begin errors++; $display("FAIL limit_disable_lag case=%0d: got %b expected %b", c, pwm_o, {3'b000, lim_exp[c]}); end
      @(negedge clk);
      checks++; if (pwm_o !== 4'b0000) begin errors++; $display("FAIL limit_disable_idle case=%0d: got %b expected 0000", c, pwm_o); end
      rd(32'h10, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL limit_disable_count case=%0d: got %h expected 0", c, d); end
    end
    // Zero period with PSC=2: a boundary on every third cycle
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd2);
    wr(32'h0C, 32'h1);
    wr(32'h00, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.we_i = 1'b0;
      rd(32'h0C, d);
      checks++; if (d !== {31'd0, (k % 3) == 0}) begin errors++; $display("FAIL psc_evt k=%0d: got %h expected %h", k, d, {31'd0, (k % 3) == 0}); end
      rd(32'h10, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL psc_count k=%0d: got %h expected 0", k, d); end
      if ((k % 3) == 0) sched_wr(32'h0C, 32'h1);
    end
    wr(32'h00, 32'h0);
    wr(32'h08, 32'd0);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        ei;
    wr(32'h04, 32'd3);
    wr(32'h0C, 32'h1);
    wr(32'h00, 32'h9);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.we_i = 1'b0;
      ei = (k >= 4 && k <= 9) || (k == 12);
      checks++; if (irq_o !== ei) begin errors++; $display("FAIL irq k=%0d: got %b expected %b", k, irq_o, ei); end
      if (k == 8) begin
        rd(32'h0C, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL irq_w1c_vs_boundary: got %b expected 1", d[0]); end
      end
      if (k == 7 || k == 9) sched_wr(32'h0C, 32'h1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq_o); end
    checks++; if (pwm_o !== 4'b0000) begin errors++; $display("FAIL midreset_pwm: got %b expected 0000", pwm_o); end
    rd(32'h00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_ctrl: got %h expected 0", d); end
    rd(32'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_period: got %h expected 0", d); end
    rd(32'h0C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h expected 0", d); end
    rd(32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_count: got %h expected 0", d); end
    rd(32'h20, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_duty0: got %h expected 0", d); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_centre();
    test_shadow();
    test_limits();
    test_irq();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
